// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// One command in, one bus cycle out, one response back; a bounded wait guards against a silent slave.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen on the last permitted stb cycle without ack
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic            r_cmd_ready, w_cmd_ready;
  logic            r_rsp_valid, w_rsp_valid;
  logic [DW-1:0]   r_rsp_dat, w_rsp_dat;
  logic            r_rsp_err, w_rsp_err;
  logic            r_cyc, w_cyc;
  logic            r_we, w_we;
  logic [SW-1:0]   r_sel, w_sel;
  logic [DW-1:0]   r_adr, w_adr;
  logic [DW-1:0]   r_dat, w_dat;

  // Next-state and next-output decode
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_rsp_valid = r_rsp_valid;
    w_rsp_dat   = r_rsp_dat;
    w_rsp_err   = r_rsp_err;
    w_cyc       = r_cyc;
    w_we        = r_we;
    w_sel       = r_sel;
    w_adr       = r_adr;
    w_dat       = r_dat;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_we    = cmd_we;
          w_sel   = cmd_sel;
          w_adr   = cmd_adr;
          w_dat   = cmd_dat;
          w_cyc   = 1'b1;
          w_cnt   = '0;
          w_state = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack takes priority over a timeout firing on the same cycle
        if (wbm_ack_i) begin
          w_cyc       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_dat   = r_we ? '0 : wbm_dat_i;
          w_rsp_err   = 1'b0;
          w_state     = ST_RESP;
        end else if (TO_EN && (r_cnt == CNT_LAST)) begin
          w_cyc       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_dat   = '0;
          w_rsp_err   = 1'b1;
          w_state     = ST_RESP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = ST_IDLE;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_cmd_ready = (w_state == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_dat   <= w_rsp_dat;
      r_rsp_err   <= w_rsp_err;
      r_cyc       <= w_cyc;
      r_we        <= w_we;
      r_sel       <= w_sel;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule
